// File: rtl/ex_stage_pkg.sv
// Shared EX-stage types: ALU opcodes, the decoded control bundle, the multiplier
// FSM states and the operand forwarding rule.
package Defs;

  typedef enum logic [3:0] {
    ADD, SUB, AND, OR, XOR, SHL, SHR, PASS_B, MUL
  } AluOp_t;

  typedef struct packed {
    AluOp_t AluOp;
    logic   AluSrc;
    logic   RegWrite;
    logic   MemRead;
    logic   MemWrite;
    logic   MemToReg;
  } ControlSignals;

  typedef enum logic {IDLE, BUSY} MulState_t;

  localparam ControlSignals CTRL_BUBBLE = '0;

  // The younger result (EX/MEM) takes priority over the older one (MEM/WB).
  function automatic logic [7:0] forward_operand(
    input logic [2:0] id,
    input logic [7:0] reg_val,
    input logic       exmem_wr,
    input logic [2:0] exmem_rd,
    input logic [7:0] exmem_val,
    input logic       wb_wr,
    input logic [2:0] wb_id,
    input logic [7:0] wb_val
  );
    if (exmem_wr && (exmem_rd == id)) return exmem_val;
    if (wb_wr && (wb_id == id))       return wb_val;
    return reg_val;
  endfunction

endpackage

// File: rtl/ex_stage_mul_seq.sv
// Multi-cycle shift-add multiplier: one iteration per edge, MUL_ITER iterations
// per product. Each iteration consumes ceil(8/MUL_ITER) multiplier bits.
module mul_seq
  import Defs::*;
#(
  parameter int MUL_ITER = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       is_mul,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       active,
  output logic       done,
  output logic [7:0] product
);

  localparam int BITS  = (8 + MUL_ITER - 1) / MUL_ITER;
  localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_ITER - 1);

  MulState_t        state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       acc, mcand, mplier;
  logic [7:0]       src_a, src_b, step_sum;

  assign busy    = (state == BUSY);
  assign active  = busy || is_mul;
  assign done    = active && (cnt == LAST);
  assign product = step_sum;

  // Iteration 0 runs on the live operands; later iterations use the latches.
  always_comb begin
    src_a    = busy ? mcand  : a;
    src_b    = busy ? mplier : b;
    step_sum = busy ? acc    : 8'd0;
    for (int j = 0; j < BITS; j++) begin
      if (src_b[j]) step_sum = step_sum + (src_a << j);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= 8'd0;
      mcand  <= 8'd0;
      mplier <= 8'd0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (active) begin
      acc    <= step_sum;
      mcand  <= src_a << BITS;
      mplier <= src_b >> BITS;
      if (done) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= BUSY;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, multi-cycle MUL with
// stall, and the EX/MEM pipeline register.
module ex_stage
  import Defs::*;
#(
  parameter int MUL_ITER = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  ControlSignals control_in,
  input  logic [7:0]    RsVal_in,
  input  logic [7:0]    RdVal_in,
  input  logic [7:0]    ImmVal_in,
  input  logic [2:0]    Rs_in,
  input  logic [2:0]    Rd_in,
  input  logic          wb_regwrite,
  input  logic [2:0]    wb_rd,
  input  logic [7:0]    wb_data,
  input  logic          flush,
  output ControlSignals control_out,
  output logic [7:0]    alu_out,
  output logic [7:0]    store_out,
  output logic [2:0]    rd_out,
  output logic          zero_out,
  output logic          stall_out
);

  logic [7:0]    fwd_rs, fwd_rd, op_a, op_b, alu_result, product;
  logic [7:0]    store_hold, fin_store, fin_result;
  logic [2:0]    rd_hold, fin_rd;
  ControlSignals ctrl_hold, fin_ctrl;
  logic          is_mul, mul_busy, mul_active, mul_done;

  assign fwd_rs = forward_operand(Rs_in, RsVal_in, control_out.RegWrite, rd_out, alu_out,
                                  wb_regwrite, wb_rd, wb_data);
  assign fwd_rd = forward_operand(Rd_in, RdVal_in, control_out.RegWrite, rd_out, alu_out,
                                  wb_regwrite, wb_rd, wb_data);

  // Two-operand form: Rd is the A operand and also the value stored by stores.
  assign op_a      = fwd_rd;
  assign op_b      = control_in.AluSrc ? ImmVal_in : fwd_rs;
  assign is_mul    = (control_in.AluOp == MUL);
  assign stall_out = reset_n && !flush && mul_active;

  always_comb begin
    alu_result = 8'd0;
    case (control_in.AluOp)
      ADD:     alu_result = op_a + op_b;
      SUB:     alu_result = op_a - op_b;
      AND:     alu_result = op_a & op_b;
      OR:      alu_result = op_a | op_b;
      XOR:     alu_result = op_a ^ op_b;
      SHL:     alu_result = op_a << op_b[2:0];
      SHR:     alu_result = op_a >> op_b[2:0];
      PASS_B:  alu_result = op_b;
      default: alu_result = 8'd0;
    endcase
  end

  mul_seq #(.MUL_ITER(MUL_ITER)) u_mul_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .is_mul  (is_mul),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .active  (mul_active),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_hold  <= CTRL_BUBBLE;
      rd_hold    <= 3'd0;
      store_hold <= 8'd0;
    end else if (!flush && !mul_busy && is_mul) begin
      ctrl_hold  <= control_in;
      rd_hold    <= Rd_in;
      store_hold <= fwd_rd;
    end
  end

  // While busy the live inputs belong to a later instruction, so use the latches.
  always_comb begin
    fin_ctrl   = mul_busy ? ctrl_hold  : control_in;
    fin_rd     = mul_busy ? rd_hold    : Rd_in;
    fin_store  = mul_busy ? store_hold : fwd_rd;
    fin_result = mul_active ? product  : alu_result;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      control_out <= CTRL_BUBBLE;
      alu_out     <= 8'd0;
      store_out   <= 8'd0;
      rd_out      <= 3'd0;
      zero_out    <= 1'b1;
    end else if (flush || (mul_active && !mul_done)) begin
      control_out <= CTRL_BUBBLE;
      alu_out     <= 8'd0;
      store_out   <= 8'd0;
      rd_out      <= 3'd0;
      zero_out    <= 1'b1;
    end else begin
      control_out <= fin_ctrl;
      alu_out     <= fin_result;
      store_out   <= fin_store;
      rd_out      <= fin_rd;
      zero_out    <= (fin_result == 8'd0);
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed literal checks plus a randomized run compared
// every cycle against an instruction-level behavioural model.
module tb_ex_stage;
  import Defs::*;

  localparam int MUL_ITER = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  ControlSignals control_in, control_out;
  logic [7:0]    RsVal_in, RdVal_in, ImmVal_in, wb_data, alu_out, store_out;
  logic [2:0]    Rs_in, Rd_in, wb_rd, rd_out;
  logic          wb_regwrite, flush, zero_out, stall_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  // Model of the EX/MEM register plus the pending multiply.
  ControlSignals m_ctrl, cap_ctrl;
  logic [7:0]    m_alu, m_store, cap_a, cap_b, cap_store;
  logic [2:0]    m_rd, cap_rd;
  logic          m_zero;
  int            mul_left;

  ex_stage #(.MUL_ITER(MUL_ITER)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .control_in  (control_in),
    .RsVal_in    (RsVal_in),
    .RdVal_in    (RdVal_in),
    .ImmVal_in   (ImmVal_in),
    .Rs_in       (Rs_in),
    .Rd_in       (Rd_in),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .control_out (control_out),
    .alu_out     (alu_out),
    .store_out   (store_out),
    .rd_out      (rd_out),
    .zero_out    (zero_out),
    .stall_out   (stall_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] model_alu(input AluOp_t op, input int a, input int b);
    int r;
    case (op)
      ADD:     r = a + b;
      SUB:     r = a - b;
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      SHL:     r = a << (b % 8);
      SHR:     r = a >> (b % 8);
      PASS_B:  r = b;
      MUL:     r = a * b;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  function automatic logic [7:0] model_fwd(input logic [2:0] id, input logic [7:0] val);
    if (m_ctrl.RegWrite && m_rd == id) return m_alu;
    if (wb_regwrite && wb_rd == id)    return wb_data;
    return val;
  endfunction

  function automatic void model_bubble();
    m_ctrl = '0; m_alu = 8'd0; m_store = 8'd0; m_rd = 3'd0; m_zero = 1'b1;
  endfunction

  function automatic void model_load(input ControlSignals c, input logic [7:0] res,
                                     input logic [7:0] st, input logic [2:0] rd);
    m_ctrl = c; m_alu = res; m_store = st; m_rd = rd; m_zero = (res == 8'd0);
  endfunction

  function automatic void model_step();
    logic [7:0] a, b;
    a = model_fwd(Rd_in, RdVal_in);
    b = control_in.AluSrc ? ImmVal_in : model_fwd(Rs_in, RsVal_in);
    if (flush) begin
      model_bubble();
      mul_left = 0;
    end else if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) model_load(cap_ctrl, model_alu(MUL, int'(cap_a), int'(cap_b)), cap_store, cap_rd);
      else model_bubble();
    end else if (control_in.AluOp == MUL) begin
      cap_ctrl = control_in; cap_a = a; cap_b = b; cap_store = a; cap_rd = Rd_in;
      mul_left = MUL_ITER - 1;
      if (mul_left == 0) model_load(cap_ctrl, model_alu(MUL, int'(cap_a), int'(cap_b)), cap_store, cap_rd);
      else model_bubble();
    end else begin
      model_load(control_in, model_alu(control_in.AluOp, int'(a), int'(b)), a, Rd_in);
    end
  endfunction

  function automatic logic model_stall();
    return reset_n && !flush && (mul_left > 0 || control_in.AluOp == MUL);
  endfunction

  always @(posedge clk) if (reset_n) model_step();

  always @(negedge reset_n) begin
    model_bubble();
    mul_left = 0;
  end

  // Registered outputs are compared 2 units after the edge, stall late in the cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (checking) begin
        checkOutput("control_out", int'(control_out), int'(m_ctrl));
        checkOutput("alu_out",     int'(alu_out),     int'(m_alu));
        checkOutput("store_out",   int'(store_out),   int'(m_store));
        checkOutput("rd_out",      int'(rd_out),      int'(m_rd));
        checkOutput("zero_out",    int'(zero_out),    int'(m_zero));
      end
      #6;
      if (checking) checkOutput("stall_out", int'(stall_out), int'(model_stall()));
    end
  end

  task automatic applyStimulus(input AluOp_t op, input logic src, input logic regw,
                               input logic [2:0] rs, input logic [2:0] rd,
                               input logic [7:0] rsv, input logic [7:0] rdv,
                               input logic [7:0] imm, input logic fl);
    control_in = '{AluOp: op, AluSrc: src, RegWrite: regw,
                   MemRead: 1'b0, MemWrite: 1'b0, MemToReg: 1'b0};
    Rs_in = rs; Rd_in = rd; RsVal_in = rsv; RdVal_in = rdv; ImmVal_in = imm; flush = fl;
  endtask

  task automatic applyNop();
    applyStimulus(ADD, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #3;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    model_bubble();
    mul_left = 0;
    wb_regwrite = 1'b0; wb_rd = 3'd0; wb_data = 8'd0;
    applyNop();
    repeat (2) @(posedge clk);
    #3;
    checkOutput("reset_alu",   int'(alu_out), 0);
    checkOutput("reset_zero",  int'(zero_out), 1);
    checkOutput("reset_ctrl",  int'(control_out), 0);
    checkOutput("reset_rd",    int'(rd_out), 0);
    checkOutput("reset_store", int'(store_out), 0);
    checkOutput("reset_stall", int'(stall_out), 0);
    reset_n = 1'b1;
    checking = 1'b1;

    // ADD with immediate wraps modulo 256
    applyStimulus(ADD, 1'b1, 1'b1, 3'd1, 3'd1, 8'hF0, 8'hF0, 8'h20, 1'b0);
    #1 checkOutput("add_imm_stall", int'(stall_out), 0);
    stepCycle();
    checkOutput("add_imm_alu",  int'(alu_out), 8'h10);
    checkOutput("add_imm_zero", int'(zero_out), 0);

    // EX/MEM forwarding beats MEM/WB
    applyStimulus(ADD, 1'b1, 1'b1, 3'd3, 3'd3, 8'd0, 8'd0, 8'd5, 1'b0);
    stepCycle();
    checkOutput("r3_write_alu", int'(alu_out), 5);
    wb_regwrite = 1'b1; wb_rd = 3'd3; wb_data = 8'd9;
    applyStimulus(SUB, 1'b0, 1'b1, 3'd3, 3'd3, 8'h77, 8'h77, 8'd0, 1'b0);
    stepCycle();
    wb_regwrite = 1'b0; wb_rd = 3'd0; wb_data = 8'd0;
    checkOutput("fwd_sub_alu",   int'(alu_out), 0);
    checkOutput("fwd_sub_zero",  int'(zero_out), 1);
    checkOutput("fwd_sub_store", int'(store_out), 5);

    // 13 x 21: eight stall cycles, seven bubbles, then 273 mod 256
    applyStimulus(MUL, 1'b0, 1'b1, 3'd5, 3'd4, 8'd21, 8'd13, 8'd0, 1'b0);
    for (int i = 0; i < MUL_ITER; i++) begin
      #1 checkOutput("mul_stall", int'(stall_out), 1);
      stepCycle();
      if (i == 0) applyNop();
      if (i < MUL_ITER - 1) begin
        checkOutput("mul_bubble_alu",  int'(alu_out), 0);
        checkOutput("mul_bubble_ctrl", int'(control_out), 0);
      end
    end
    checkOutput("mul_product", int'(alu_out), 8'h11);
    checkOutput("mul_rd",      int'(rd_out), 4);
    checkOutput("mul_regwr",   int'(control_out.RegWrite), 1);
    checkOutput("mul_store",   int'(store_out), 13);
    #1 checkOutput("mul_after_stall", int'(stall_out), 0);
    stepCycle();

    // Product forwarded into the next instruction with no extra stall
    applyStimulus(MUL, 1'b0, 1'b1, 3'd6, 3'd2, 8'd3, 8'd2, 8'd0, 1'b0);
    stepCycle();
    applyStimulus(AND, 1'b1, 1'b1, 3'd2, 3'd2, 8'hFF, 8'hFF, 8'h03, 1'b0);
    repeat (MUL_ITER - 1) stepCycle();
    checkOutput("mul6_product", int'(alu_out), 6);
    #1 checkOutput("dep_and_stall", int'(stall_out), 0);
    stepCycle();
    checkOutput("dep_and_alu", int'(alu_out), 2);

    // Flush in the fourth MUL cycle
    applyStimulus(MUL, 1'b0, 1'b1, 3'd6, 3'd5, 8'd4, 8'd3, 8'd0, 1'b0);
    stepCycle();
    applyNop();
    stepCycle();
    stepCycle();
    applyStimulus(ADD, 1'b1, 1'b1, 3'd7, 3'd7, 8'h55, 8'h55, 8'h01, 1'b1);
    #1 checkOutput("flush_stall", int'(stall_out), 0);
    stepCycle();
    checkOutput("flush_bubble_alu",  int'(alu_out), 0);
    checkOutput("flush_bubble_ctrl", int'(control_out), 0);
    applyStimulus(ADD, 1'b1, 1'b1, 3'd6, 3'd6, 8'd7, 8'd7, 8'd8, 1'b0);
    #1 checkOutput("post_flush_stall", int'(stall_out), 0);
    stepCycle();
    checkOutput("post_flush_alu", int'(alu_out), 15);

    // Asynchronous reset pulse in the middle of a MUL
    applyStimulus(MUL, 1'b0, 1'b1, 3'd5, 3'd4, 8'd21, 8'd13, 8'd0, 1'b0);
    stepCycle();
    applyNop();
    stepCycle();
    applyStimulus(MUL, 1'b0, 1'b1, 3'd5, 3'd4, 8'd21, 8'd13, 8'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_alu",   int'(alu_out), 0);
    checkOutput("rst_mid_zero",  int'(zero_out), 1);
    checkOutput("rst_mid_ctrl",  int'(control_out), 0);
    checkOutput("rst_mid_rd",    int'(rd_out), 0);
    checkOutput("rst_mid_stall", int'(stall_out), 0);
    #1 reset_n = 1'b1;
    applyNop();
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("rst_no_product", int'(alu_out), 0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      AluOp_t op;
      int     r;
      r  = int'($urandom_range(0, 9));
      op = (r >= 8) ? MUL : AluOp_t'(r);
      applyStimulus(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                    8'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 15) == 0));
      control_in.MemRead  = 1'($urandom_range(0, 1));
      control_in.MemWrite = 1'($urandom_range(0, 1));
      control_in.MemToReg = 1'($urandom_range(0, 1));
      wb_regwrite = 1'($urandom_range(0, 1));
      wb_rd       = 3'($urandom_range(0, 3));
      wb_data     = 8'($urandom);
      stepCycle();
    end

    applyNop();
    wb_regwrite = 1'b0;
    repeat (MUL_ITER + 2) stepCycle();
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: MUL_ITER, default 8, number of shift-add iterations (one per cycle) for MUL; legal values 1-8.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 control_in  input  ControlSignals  decoded control from the ID/EX register.
REQ-005 RsVal_in, RdVal_in, ImmVal_in  input  8 each  operands from the ID/EX register.
REQ-006 Rs_in, Rd_in  input  3 each  source and destination register IDs.
REQ-007 wb_regwrite, wb_rd, wb_data  input  1/3/8  MEM/WB write-back, used for forwarding.
REQ-008 flush  input  1  branch squash of the instruction in EX.
REQ-009 control_out  output  ControlSignals  EX/MEM control.
REQ-010 alu_out, store_out  output  8 each  EX/MEM result and forwarded Rd value for stores.
REQ-011 rd_out  output  3  EX/MEM destination ID.
REQ-012 zero_out  output  1  registered (result == 0).
REQ-013 stall_out  output  1  combinational; when high, the upstream stages and ID/EX hold.

Function
REQ-014 Forwarding for each operand (Rs, Rd): EX/MEM (control_out.RegWrite && rd_out == ID) first; else MEM/WB (wb_regwrite && wb_rd == ID); else the register value; r0 is not special-cased.
REQ-015 Operand B is ImmVal_in when control_in.AluSrc = 1, else the forwarded Rs.
REQ-016 AluOp_t: ADD, SUB, AND, OR, XOR, SHL, SHR (shift amount B[2:0], zero fill), PASS_B, MUL; all results are modulo 256.
REQ-017 Non-MUL ops: 1-cycle latency; outputs load on the edge that ends the presentation cycle.
REQ-018 FSM states: IDLE and BUSY, plus a counter cnt of 0..MUL_ITER-1.
REQ-019 IDLE with AluOp = MUL: stall_out = 1; forwarded operands are captured at the edge; iteration 0 executes; the next state is BUSY with cnt = 1 (or stays IDLE if MUL_ITER = 1).
REQ-020 BUSY: stall_out = 1; control_in and operands are ignored; one iteration per edge.
REQ-021 BUSY exits to IDLE on the edge where cnt = MUL_ITER-1; that edge loads the low 8 bits of the product with the captured control and rd.
REQ-022 stall_out is high for exactly MUL_ITER consecutive cycles per MUL.
REQ-023 Each non-final MUL edge loads a bubble: control_out = '0, alu_out = 0, store_out = 0, rd_out = 0.
REQ-024 flush high: the next edge loads a bubble and forces IDLE with cnt = 0. stall_out is 0 in that cycle. flush overrides all other conditions, including a MUL in progress.
REQ-025 A MUL immediately followed by a dependent instruction: the product is forwarded from EX/MEM with no extra stall.
REQ-026 zero_out reflects the loaded alu_out; a bubble gives zero_out = 1.

Reset
REQ-027 reset_n low asynchronously sets control_out = '0, alu_out = 0, store_out = 0, rd_out = 0, zero_out = 1, state = IDLE, cnt = 0, and operand latches = 0.
REQ-028 Reset asserted during a MUL abandons the MUL with no result; stall_out = 0 while reset is active.

Structure
REQ-029 The AluOp_t enum and the ControlSignals fields AluOp, AluSrc, RegWrite, MemRead, MemWrite and MemToReg shall live in package Defs.
REQ-030 One sub-module, mul_seq (shift-add FSM, counter, product accumulator), instantiated by ex_stage; the forwarding muxes and the ALU stay inline.

Verification
REQ-031 ADD with AluSrc = 1, RsVal = 8'hF0, Imm = 8'h20 -> after 1 edge: alu_out = 8'h10, zero_out = 0, stall_out never high.
REQ-032 ADD writing r3 = 5, then SUB r3 - r3 in the next cycle -> EX/MEM forward, alu_out = 0, zero_out = 1; with wb_rd = 3 and wb_data = 9 also present, EX/MEM still wins.
REQ-033 MUL 8'd13 x 8'd21, MUL_ITER = 8 -> stall_out high for 8 cycles, 7 bubbles, then alu_out = 8'h11 (273 mod 256).
REQ-034 flush asserted in the 4th cycle of a MUL -> next edge loads a bubble, stall_out = 0, state IDLE; the following ADD completes in 1 cycle.
REQ-035 reset_n pulsed low mid-MUL, between clock edges -> outputs go to their reset values immediately, stall_out = 0, and no product ever appears.
REQ-036 MUL result 8'd6 to r2, followed by AND r2, Imm 8'h03 -> alu_out = 8'h02 with no stall after the MUL.
